// File: rtl/rx_frame_counter_if.sv
// Bundle of the XGMII word-tracking inputs and the lane-aligned strobes
// handed to the frame-departure stage.
interface rx_frame_counter_if;
   logic        get_sfd;
   logic        get_efd;
   logic        get_error_code;
   logic [15:0] lt_data;
   logic [15:0] tagged_len;

   logic        start_da;
   logic        start_lt;
   logic        tagged_frame;
   logic        end_data_cnt;
   logic [2:0]  bits_more;
   logic        small_frame;
   logic        end_small_cnt;
   logic [2:0]  small_bits_more;
   logic        receiving;
   logic        receiving_frame;
   logic        frame_err;
   logic [1:0]  err_code;

   modport master (
      output get_sfd, get_efd, get_error_code, lt_data, tagged_len,
      input  start_da, start_lt, tagged_frame, end_data_cnt, bits_more,
             small_frame, end_small_cnt, small_bits_more, receiving,
             receiving_frame, frame_err, err_code
   );

   modport slave (
      input  get_sfd, get_efd, get_error_code, lt_data, tagged_len,
      output start_da, start_lt, tagged_frame, end_data_cnt, bits_more,
             small_frame, end_small_cnt, small_bits_more, receiving,
             receiving_frame, frame_err, err_code
   );
endinterface

// File: rtl/rx_frame_counter.sv
// Receive-side frame sequencer: follows one XGMII frame from SFD to EFD and
// produces word-aligned strobes plus length/oversize/abort error reporting.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | between frames, waiting for an SFD word
//   DA     | word 1, destination address
//   LT     | word 2, length/type field
//   DATA   | word 3 onward, tracking payload until EFD
//   DROP   | frame already in error, discarding words until EFD
module rx_frame_counter #(
   parameter int MAX_BYTES = 1522,
   parameter int CNT_W     = 12
) (
   input  logic              rxclk_180,
   input  logic              reset,
   rx_frame_counter_if.slave rx
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DA   = 3'd1,
      S_LT   = 3'd2,
      S_DATA = 3'd3,
      S_DROP = 3'd4
   } state_t;

   localparam logic [15:0] TPID     = 16'h8100;
   localparam logic [31:0] OVER_LIM = 32'(MAX_BYTES + 8);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             tagged_q, tagged_d;
   logic [1:0]       pend_err_q, pend_err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             frame_err_q, frame_err_d;

   logic             tag_hit;
   logic             dec_ok;
   logic             len_mode;
   logic             type_mode;
   logic [15:0]      len;
   logic [16:0]      hdr;
   logic [16:0]      dlen;
   logic [16:0]      tot;
   logic [16:0]      small_tot;
   logic [16:0]      end_word;
   logic [16:0]      small_word;
   logic [16:0]      wc_ext;
   logic [CNT_W+2:0] wc_bytes;
   logic             over_size;
   logic             efd_early;
   logic             efd_late;
   logic             recv;
   logic             end_hit;
   logic             small_hit;
   logic             small_act;
   logic             done;
   logic [1:0]       done_code;

   // Length/type decode; the untagged decode waits for word 4 so a tag seen
   // on word 3 is known before any length-derived strobe is produced.
   always_comb begin
      wc_ext    = 17'(word_cnt_q);
      wc_bytes  = {word_cnt_q, 3'b000};
      tag_hit   = (state_q == S_DATA) && (word_cnt_q >= CNT_W'(3)) && (rx.lt_data == TPID);
      len       = tagged_q ? rx.tagged_len : rx.lt_data;
      hdr       = tagged_q ? 17'd18 : 17'd14;
      len_mode  = (len <= 16'd1500);
      type_mode = (len >= 16'h0600);
      dlen      = (len < 16'd46) ? 17'd46 : {1'b0, len};
      tot       = hdr + dlen;
      small_tot = hdr + {1'b0, len};
      end_word  = {3'b000, tot[16:3]} + 17'd1;
      small_word = {3'b000, small_tot[16:3]} + 17'd1;
      dec_ok    = (state_q == S_DATA) && (word_cnt_q >= CNT_W'(4));
      over_size = ({{(29-CNT_W){1'b0}}, wc_bytes} > OVER_LIM);
      efd_late  = dec_ok && len_mode && (wc_ext > end_word);
      if (!dec_ok) begin
         // EFD on word 3: only an untagged type frame can legitimately be that short
         efd_early = !((rx.lt_data >= 16'h0600) && (rx.lt_data != TPID));
      end else if (len_mode) begin
         efd_early = (wc_ext < end_word);
      end else begin
         efd_early = !type_mode;
      end
      end_hit   = dec_ok && len_mode && (wc_ext == end_word);
      small_act = dec_ok && len_mode && (len < 16'd46);
      small_hit = small_act && (wc_ext == small_word);
   end

   // receiving covers DA through the word holding the last FCS byte
   always_comb begin
      recv = 1'b0;
      case (state_q)
         S_DA, S_LT: recv = 1'b1;
         S_DATA: begin
            if (!dec_ok || !len_mode) begin
               recv = 1'b1;
            end else begin
               recv = (wc_ext <= (end_word + ((tot[2:0] > 3'd4) ? 17'd1 : 17'd0)));
            end
         end
         default: recv = 1'b0;
      endcase
   end

   // Next-state, counter and error bookkeeping
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      tagged_d    = tagged_q | tag_hit;
      pend_err_d  = pend_err_q;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      done        = 1'b0;
      done_code   = 2'b00;

      if ((state_q != S_IDLE) && (word_cnt_q != '1)) begin
         word_cnt_d = word_cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (rx.get_sfd) begin
               state_d    = S_DA;
               word_cnt_d = CNT_W'(1);
               tagged_d   = 1'b0;
               pend_err_d = 2'b00;
               err_code_d = 2'b00;
            end
         end
         S_DA: state_d = S_LT;
         S_LT: state_d = S_DATA;
         S_DATA: begin
            if (rx.get_error_code) begin
               if (rx.get_efd) begin
                  done      = 1'b1;
                  done_code = 2'b11;
               end else begin
                  state_d    = S_DROP;
                  pend_err_d = 2'b11;
               end
            end else if (rx.get_efd) begin
               done      = 1'b1;
               done_code = efd_early ? 2'b01 : 2'b00;
            end else if (over_size) begin
               state_d    = S_DROP;
               pend_err_d = 2'b10;
            end else if (efd_late) begin
               state_d    = S_DROP;
               pend_err_d = 2'b01;
            end
         end
         S_DROP: begin
            if (rx.get_efd) begin
               done      = 1'b1;
               done_code = pend_err_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (done) begin
         state_d     = S_IDLE;
         word_cnt_d  = '0;
         tagged_d    = 1'b0;
         pend_err_d  = 2'b00;
         frame_err_d = |done_code;
         if (|done_code) begin
            err_code_d = done_code;
         end
      end

      // A fresh SFD mid-frame abandons the current frame and starts over at DA
      if (rx.get_sfd && (state_q != S_IDLE)) begin
         state_d     = S_DA;
         word_cnt_d  = CNT_W'(1);
         tagged_d    = 1'b0;
         pend_err_d  = 2'b00;
         frame_err_d = 1'b1;
         err_code_d  = 2'b11;
      end
   end

   // State and status registers
   always_ff @(posedge rxclk_180 or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         word_cnt_q  <= '0;
         tagged_q    <= 1'b0;
         pend_err_q  <= 2'b00;
         err_code_q  <= 2'b00;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         tagged_q    <= tagged_d;
         pend_err_q  <= pend_err_d;
         err_code_q  <= err_code_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx.start_da        = (state_q == S_DA);
   assign rx.start_lt        = (state_q == S_LT);
   assign rx.tagged_frame    = tagged_q | tag_hit;
   assign rx.end_data_cnt    = end_hit;
   assign rx.bits_more       = end_hit ? tot[2:0] : 3'd0;
   assign rx.small_frame     = small_act;
   assign rx.end_small_cnt   = small_hit;
   assign rx.small_bits_more = small_hit ? small_tot[2:0] : 3'd0;
   assign rx.receiving       = recv;
   assign rx.receiving_frame = (state_q != S_IDLE);
   assign rx.frame_err       = frame_err_q;
   assign rx.err_code        = err_code_q;

endmodule
